// File: rtl/sw_debounce_irq_ctrl.sv
// Slide-switch input controller with an Avalon-MM slave interface.
// Raw switch inputs are synchronised, debounced on a slow sample tick,
// and accepted changes are reported as per-bit edge captures that can
// raise a maskable level interrupt.
module sw_debounce_irq_ctrl #(
    parameter int WIDTH      = 10,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int TCK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [TCK_W-1:0] TICK_LAST = TCK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CNT - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;

    logic [WIDTH-1:0]   sync1_q, sync1_d;
    logic [WIDTH-1:0]   sync2_q, sync2_d;
    logic [TCK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               tick;

    logic [CNT_W-1:0]   cnt_q [WIDTH];
    logic [CNT_W-1:0]   cnt_d [WIDTH];
    logic [WIDTH-1:0]   debounced_q, debounced_d;
    logic [WIDTH-1:0]   ev;
    logic [WIDTH-1:0]   ev_qual;

    logic [WIDTH-1:0]   irqmask_q, irqmask_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   edgecap_q, edgecap_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;
    logic               wr_en;

    // Only the low WIDTH bits (and 3 bits for CTRL) of a write are stored.
    logic               unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en    = chipselect && !write_n;
    assign readdata = readdata_q;
    assign irq      = irq_q;

    // Two-flop synchroniser input and the free-running sample tick divider.
    always_comb begin
        sync1_d    = in_port;
        sync2_d    = sync1_q;
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Debounce FSM: INIT seeds the debounced value on the first tick, RUN
    // filters each bit (or follows the input directly in bypass mode).
    always_comb begin
        state_d     = state_q;
        debounced_d = debounced_q;
        cnt_d       = cnt_q;
        ev          = '0;
        case (state_q)
            ST_INIT: begin
                if (tick) begin
                    debounced_d = sync2_q;
                    for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ctrl_q[2]) begin
                    ev          = sync2_q ^ debounced_q;
                    debounced_d = sync2_q;
                    for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
                end else if (tick) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2_q[i] == debounced_q[i]) begin
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            debounced_d[i] = sync2_q[i];
                            cnt_d[i]       = '0;
                            ev[i]          = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Register file, edge qualification/capture, read mux and interrupt.
    always_comb begin
        case (ctrl_q[1:0])
            2'd0:    ev_qual = ev & debounced_d;
            2'd1:    ev_qual = ev & ~debounced_d;
            default: ev_qual = ev;
        endcase

        irqmask_d = irqmask_q;
        ctrl_d    = ctrl_q;
        edgecap_d = edgecap_q;
        if (wr_en) begin
            case (address)
                2'd1:    irqmask_d = writedata[WIDTH-1:0];
                2'd2:    ctrl_d    = writedata[2:0];
                2'd3:    edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        // A new edge overrides a same-cycle clear.
        edgecap_d = edgecap_d | ev_qual;

        case (address)
            2'd0:    readdata_d = 32'(debounced_q);
            2'd1:    readdata_d = 32'(irqmask_q);
            2'd2:    readdata_d = 32'(ctrl_q);
            default: readdata_d = 32'(edgecap_q);
        endcase

        irq_d = |(edgecap_q & irqmask_q);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_INIT;
        else          state_q <= state_d;
    end

    // Datapath and register-file flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            tick_cnt_q  <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            debounced_q <= '0;
            irqmask_q   <= '0;
            ctrl_q      <= '0;
            edgecap_q   <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tick_cnt_q  <= tick_cnt_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            debounced_q <= debounced_d;
            irqmask_q   <= irqmask_d;
            ctrl_q      <= ctrl_d;
            edgecap_q   <= edgecap_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: doc/sw_debounce_irq_ctrl.md
Name: sw_debounce_irq_ctrl

Overview:
- Avalon-MM slave controller for the 10-bit slide-switch input port.
- Synchronises and debounces the switches on a programmable sample tick, then captures edges per bit and raises a maskable interrupt to the Nios II.
- Replaces a raw PIO read path, so software sees only stable switch values and edge events.

Parameters:
- WIDTH, 10, number of switch bits (1..32).
- TICK_DIV, 50000, clk cycles per sample tick (>=2).
- STABLE_CNT, 4, consecutive differing samples required to accept a change (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw, asynchronous switch inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk.
- On reset, all of the following clear to 0:
  - readdata, irq;
  - sync flops, tick counter, per-bit stability counters;
  - debounced, irqmask, ctrl, edgecap.
- On reset, the FSM enters INIT.
- Synchroniser: two flops per bit, in_port to sync; no other logic touches in_port.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for one cycle when count == TICK_DIV-1.
  - Free-running from reset.
- FSM INIT:
  - On the first tick, load debounced <= sync and clear all stability counters.
  - No edges are captured. Go to RUN.
  - INIT lasts exactly TICK_DIV cycles after reset release.
- FSM RUN, per bit i, only on tick:
  - If sync[i] == debounced[i], cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CNT-1, then debounced[i] <= sync[i], cnt[i] <= 0, and edge event ev[i] fires for that cycle.
  - Else cnt[i] <= cnt[i]+1.
  - Any matching sample (bounce) restarts the count.
- Edge qualification, by ctrl[1:0]:
  - 0: rising only (new value 1).
  - 1: falling only.
  - 2 or 3: both.
  - Qualified ev[i] sets edgecap[i].
- Debounce bypass, ctrl[2] = 1:
  - debounced <= sync every clk and counters are held at 0.
  - Edge events are generated per clk.
  - INIT still completes on the first tick before any edge is captured.
- Registers (bits above WIDTH read 0, writes ignored):
  - 0 DATA: RO, debounced.
  - 1 IRQMASK: RW, irqmask.
  - 2 CTRL: RW, bits [2:0].
  - 3 EDGECAP: read returns edgecap; write-1-to-clear.
- Write occurs when chipselect && !write_n; writes to DATA have no effect.
- Simultaneous W1C and a new qualified edge on the same bit in the same cycle: the edge wins and the bit stays 1.
- readdata:
  - Registered every clk from address, zero-extended; read latency 1 cycle.
  - Reflects register state as of the previous clock edge.
- irq:
  - Registered as irq <= |(edgecap & irqmask), so it asserts 1 cycle after edgecap/irqmask update.
  - Deasserts 1 cycle after clear or mask.
- Reset asserted mid-debounce: all state drops immediately, FSM returns to INIT, no spurious edge is captured after release.
- Counter width for cnt: ceil(log2(STABLE_CNT)), minimum 1 bit. STABLE_CNT=1 accepts a change on the first differing tick.

Test Plan (TICK_DIV=4, STABLE_CNT=3, WIDTH=10 unless stated):
- in_port=10'h3FF held through reset release:
  - DATA reads 0 until the first tick, then 10'h3FF.
  - EDGECAP stays 0 and irq stays 0.
- After INIT, with in_port=0, ctrl=0, irqmask=10'h001, raise in_port[0]:
  - DATA[0] goes to 1 on the 3rd tick after sync (about 2+12 clk).
  - edgecap=10'h001 the same cycle; irq=1 one cycle later.
- Bounce on in_port[5] with pattern 1,1,0,1,1,1 across successive ticks:
  - Accepted only after the final three 1s.
  - Exactly one edge is captured.
- Write EDGECAP=32'h1 in the same cycle a new rising edge on bit 0 is accepted:
  - edgecap[0] remains 1 and irq stays high.
  - A later W1C clears it, and irq drops 1 cycle after the write.
- ctrl=1 (falling only), toggle bit 3 0->1->0:
  - Only the falling transition sets edgecap[3].
  - With irqmask=0, irq stays 0 while EDGECAP reads 10'h008.
- Assert reset_n low while cnt[2]=2 with a change pending:
  - After release, all registers read 0 and the FSM re-enters INIT.
  - The pending change loads silently, with no edge captured.
